// File: rtl/ram_master_pkg.sv
// Shared types and constants for the byte-serialising ram word master.
package ram_master_pkg;
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    localparam int WORDBYTES = 8;
    localparam int LANE_W    = 3;
endpackage

// File: rtl/ram_word_master.sv
// Turns 64-bit load/store requests into 8 little-endian byte accesses on one
// port of a byte-wide ram and returns a 64-bit response with a range-ok flag.
module ram_word_master
    import ram_master_pkg::*;
#(
    parameter int memsize   = 8192,
    parameter int addrsize  = 13,
    parameter int wordbytes = WORDBYTES
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [63:0]         req_addr,
    input  logic [63:0]         req_wdata,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [63:0]         rsp_rdata,
    output logic                rsp_ok,
    output logic [addrsize-1:0] ram_addr,
    output logic                ram_wen,
    output logic [7:0]          ram_wdat,
    output logic                ram_ren,
    input  logic [7:0]          ram_rdat
);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(wordbytes - 1);

    state_t              state, next;
    logic [LANE_W-1:0]   cnt;
    logic                wr_q, ok_q;
    logic [addrsize-1:0] addr_q;
    logic [63:0]         wdata_q, rdata_q;
    logic                in_range;

    // 65-bit sum so addresses near 2^64 cannot wrap back into range.
    assign in_range = ({1'b0, req_addr} + 65'(wordbytes)) <= 65'(memsize);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= next;
    end

    always_comb begin
        next = state;
        case (state)
            IDLE:    if (req_valid) next = in_range ? ACCESS : RESP;
            ACCESS:  if (cnt == LAST_LANE) next = RESP;
            RESP:    if (rsp_ready) next = IDLE;
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cnt     <= '0;
            wr_q    <= 1'b0;
            ok_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    wr_q    <= req_write;
                    addr_q  <= req_addr[addrsize-1:0];
                    wdata_q <= req_wdata;
                    rdata_q <= '0;
                    ok_q    <= in_range;
                    cnt     <= '0;
                end
                ACCESS: begin
                    if (!wr_q) rdata_q[{cnt, 3'b000} +: 8] <= ram_rdat;
                    cnt <= cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // All outputs decode from state so a reset forces them back immediately.
    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign rsp_ok    = (state == RESP) && ok_q;
    assign rsp_rdata = (state == RESP) ? rdata_q : '0;
    assign ram_wen   = (state == ACCESS) && wr_q;
    assign ram_ren   = (state == ACCESS) && !wr_q;
    assign ram_addr  = (state == ACCESS) ? addr_q + addrsize'(cnt) : '0;
    assign ram_wdat  = ram_wen ? wdata_q[{cnt, 3'b000} +: 8] : 8'h00;
endmodule

// File: tb/tb_ram_word_master.sv
// Directed bench for ram_word_master with a byte-array ram, a transaction-level
// reference model and a per-cycle compare process.
module tb_ram_word_master;
    localparam int MEM = 8192;
    localparam int AW  = 13;

    logic          clock = 1'b0;
    logic          resetn = 1'b0;
    logic          req_valid = 1'b0, req_write = 1'b0, rsp_ready = 1'b1;
    logic [63:0]   req_addr = '0, req_wdata = '0;
    logic          req_ready, rsp_valid, rsp_ok, ram_wen, ram_ren;
    logic [63:0]   rsp_rdata;
    logic [AW-1:0] ram_addr;
    logic [7:0]    ram_wdat, ram_rdat;

    int nchecks = 0;
    int nerr    = 0;

    always #5 clock = ~clock;

    ram_word_master #(.memsize(MEM), .addrsize(AW), .wordbytes(8)) dut (
        .clock(clock), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_ok(rsp_ok),
        .ram_addr(ram_addr), .ram_wen(ram_wen), .ram_wdat(ram_wdat),
        .ram_ren(ram_ren), .ram_rdat(ram_rdat)
    );

    // Port A of the ram: combinational read, write on posedge.
    logic [7:0] ram [0:MEM-1];
    logic [7:0] ref_mem [0:MEM-1];
    assign ram_rdat = ram[ram_addr];
    always @(posedge clock) if (ram_wen) ram[ram_addr] <= ram_wdat;

    initial begin
        for (int i = 0; i < MEM; i++) begin
            ram[i]     = 8'(i) ^ 8'hA5;
            ref_mem[i] = 8'(i) ^ 8'hA5;
        end
    end

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        nchecks++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    // Reference model: one transaction at a time, tracked by cycles since acceptance.
    logic        m_busy = 1'b0, m_wr = 1'b0, m_ok = 1'b0;
    logic [63:0] m_addr = '0, m_wdata = '0, m_rdata = '0;
    int          m_cyc = 0, m_lat = 0;

    function automatic logic [63:0] model_load(input logic [63:0] a);
        logic [63:0] r;
        for (int k = 0; k < 8; k++) r[8*k +: 8] = ref_mem[int'(a[12:0]) + k];
        return r;
    endfunction

    always @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            m_busy <= 1'b0;
            m_cyc  <= 0;
        end else if (m_busy) begin
            if (m_ok && m_wr && m_cyc >= 1 && m_cyc <= 8)
                ref_mem[int'(m_addr[12:0]) + m_cyc - 1] <= m_wdata[8*(m_cyc-1) +: 8];
            if (m_cyc >= m_lat && rsp_ready) m_busy <= 1'b0;
            else                             m_cyc  <= m_cyc + 1;
        end else if (req_valid) begin
            m_busy  <= 1'b1;
            m_cyc   <= 1;
            m_wr    <= req_write;
            m_addr  <= req_addr;
            m_wdata <= req_wdata;
            m_ok    <= ({1'b0, req_addr} + 65'd8) <= 65'(MEM);
            m_lat   <= (({1'b0, req_addr} + 65'd8) <= 65'(MEM)) ? 9 : 1;
            m_rdata <= (!req_write && (({1'b0, req_addr} + 65'd8) <= 65'(MEM)))
                       ? model_load(req_addr) : 64'h0;
        end
    end

    // Per-cycle comparison of every meaningful output against the model.
    always @(negedge clock) begin
        if (resetn) begin
            logic en_exp;
            en_exp = m_busy && m_ok && m_cyc >= 1 && m_cyc <= 8;
            chk("req_ready", 64'(req_ready), 64'(!m_busy));
            chk("rsp_valid", 64'(rsp_valid), 64'(m_busy && m_cyc >= m_lat));
            chk("ram_wen", 64'(ram_wen), 64'(en_exp && m_wr));
            chk("ram_ren", 64'(ram_ren), 64'(en_exp && !m_wr));
            if (en_exp) begin
                chk("ram_addr", 64'(ram_addr), 64'(AW'(m_addr[AW-1:0] + AW'(m_cyc - 1))));
                if (m_wr) chk("ram_wdat", 64'(ram_wdat), 64'(m_wdata[8*(m_cyc-1) +: 8]));
            end
            if (rsp_valid) begin
                chk("rsp_rdata", rsp_rdata, m_rdata);
                chk("rsp_ok", 64'(rsp_ok), 64'(m_ok));
            end
        end
    end

    // Issue one request; called and returns at posedge+1.
    task automatic do_req(input logic w, input logic [63:0] a, input logic [63:0] d,
                          input bit stall, output logic [63:0] rd, output logic ok,
                          output int lat);
        bit acc, got;
        req_write = w; req_addr = a; req_wdata = d; req_valid = 1'b1;
        if (stall) rsp_ready = 1'b0;
        acc = 0;
        for (int k = 0; k < 20 && !acc; k++) begin
            @(posedge clock);
            acc = req_ready;
        end
        #1;
        // Busy-time junk on the request bus must be ignored.
        req_write = ~w; req_addr = ~a; req_wdata = ~d;
        if (!stall) req_valid = 1'b0;
        if (!acc) chk("accept_timeout", 64'(acc), 64'd1);
        lat = 0; got = 0;
        for (int k = 0; k < 30 && !got; k++) begin
            @(negedge clock);
            lat++;
            got = rsp_valid;
        end
        if (!got) chk("rsp_timeout", 64'(got), 64'd1);
        rd = rsp_rdata; ok = rsp_ok;
        if (stall) begin
            repeat (5) @(negedge clock);
            #1;
            req_valid = 1'b0;
            rsp_ready = 1'b1;
        end
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic [63:0] rd, v;
        logic        ok;
        int          lat;

        #2;
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_rdata", rsp_rdata, 64'd0);
        chk("rst_rsp_ok", 64'(rsp_ok), 64'd0);
        chk("rst_ram_en", 64'({ram_wen, ram_ren}), 64'd0);
        chk("rst_ram_addr", 64'(ram_addr), 64'd0);
        chk("rst_ram_wdat", 64'(ram_wdat), 64'd0);
        @(posedge clock); #1;
        resetn = 1'b1;
        @(posedge clock); #1;

        v = 64'h1122_3344_5566_7788;
        do_req(1'b1, 64'h10, v, 0, rd, ok, lat);
        chk("st_ok", 64'(ok), 64'd1);
        chk("st_rdata", rd, 64'd0);
        chk("st_lat", 64'(lat), 64'd9);
        for (int k = 0; k < 8; k++) chk("st_byte", 64'(ram[16 + k]), 64'(v[8*k +: 8]));

        do_req(1'b0, 64'h10, 64'h0, 0, rd, ok, lat);
        chk("ld_rdata", rd, 64'h1122_3344_5566_7788);
        chk("ld_ok", 64'(ok), 64'd1);
        chk("ld_lat", 64'(lat), 64'd9);

        do_req(1'b0, 64'h13, 64'h0, 0, rd, ok, lat);
        chk("ld_unaligned", rd, 64'hBFBC_BD11_2233_4455);

        do_req(1'b0, 64'd8185, 64'h0, 0, rd, ok, lat);
        chk("oor_ok", 64'(ok), 64'd0);
        chk("oor_rdata", rd, 64'd0);
        chk("oor_lat", 64'(lat), 64'd1);

        do_req(1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'h0, 0, rd, ok, lat);
        chk("wrap_ok", 64'(ok), 64'd0);
        chk("wrap_lat", 64'(lat), 64'd1);

        do_req(1'b0, 64'd8184, 64'h0, 0, rd, ok, lat);
        chk("edge_ok", 64'(ok), 64'd1);
        chk("edge_rdata", rd, 64'h5A5B_5859_5E5F_5C5D);

        do_req(1'b0, 64'h10, 64'h0, 1, rd, ok, lat);
        chk("stall_rdata", rd, 64'h1122_3344_5566_7788);
        chk("stall_post_ready", 64'(req_ready), 64'd1);

        // Abort a store while byte 3 is on the bus.
        req_write = 1'b1; req_addr = 64'h40; req_wdata = 64'hAAAA_AAAA_AAAA_AAAA; req_valid = 1'b1;
        @(posedge clock);
        chk("abort_accept", 64'(req_ready), 64'd1);
        #1 req_valid = 1'b0;
        repeat (3) @(posedge clock);
        #1 resetn = 1'b0;
        #1;
        chk("abort_req_ready", 64'(req_ready), 64'd1);
        chk("abort_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("abort_ram_en", 64'({ram_wen, ram_ren}), 64'd0);
        chk("abort_ram_addr", 64'(ram_addr), 64'd0);
        @(posedge clock); #1;
        resetn = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        chk("abort_byte42", 64'(ram[16'h42]), 64'hAA);
        chk("abort_byte43", 64'(ram[16'h43]), 64'hE6);

        do_req(1'b0, 64'h40, 64'h0, 0, rd, ok, lat);
        chk("abort_readback", rd, 64'hE2E3_E0E1_E6AA_AAAA);

        repeat (2) @(posedge clock);
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule
